// File: rtl/ucsbece154b_perf_monitor.sv
// Performance monitor for the N-issue core: per-slot event classification, saturating
// event counters and a run FSM (IDLE/RUN/DONE). Optional histogram under `PERF_HIST_EN`.

module ucsbece154b_perf_lane #(
  parameter logic [31:0] PC_LIMIT = 32'h0001_0060
) (
  input  logic        valid,
  input  logic [31:0] pc,
  input  logic [6:0]  op,
  input  logic        mispred,
  input  logic        taken,
  output logic        instr,
  output logic        br,
  output logic        br_miss,
  output logic        jmp,
  output logic        jmp_miss
);
  assign instr    = valid && (pc != 32'd0) && (pc < PC_LIMIT);
  assign br       = valid && (op == 7'b1100011);
  assign br_miss  = br && mispred;
  assign jmp      = valid && ((op == 7'b1101111) || (op == 7'b1100111));
  assign jmp_miss = jmp && !taken;
endmodule

module ucsbece154b_perf_monitor #(
  parameter int          ISSUE_W  = 2,
  parameter int          CNT_W    = 32,
  parameter logic [31:0] HALT_PC  = 32'h0001_005c,
  parameter logic [31:0] PC_LIMIT = 32'h0001_0060,
  parameter int          MAX_CYC  = 500
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start_i,
  input  logic                   clear_i,
  input  logic [31:0]            pcf_i,
  input  logic [ISSUE_W-1:0]     valid_e_i,
  input  logic [32*ISSUE_W-1:0]  pc_e_i,
  input  logic [7*ISSUE_W-1:0]   op_e_i,
  input  logic [ISSUE_W-1:0]     mispred_i,
  input  logic [ISSUE_W-1:0]     taken_i,
  input  logic [3:0]             rd_sel_i,
  output logic [CNT_W-1:0]       rd_data_o,
  output logic                   running_o,
  output logic                   done_o,
  output logic                   timeout_o
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  localparam int NCNT = 6;

  state_t             state;
  logic [31:0]        prev_pcf;
  logic               prev_vld;
  logic [CNT_W-1:0]   cnt [NCNT];
  logic [2:0]         inc [NCNT];
  logic [ISSUE_W-1:0] l_instr, l_br, l_br_miss, l_jmp, l_jmp_miss;
  logic               halt, tmo, cnt_en;

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a, input logic [2:0] b);
    logic [CNT_W:0] s;
    s = {1'b0, a} + (CNT_W+1)'(b);
    return s[CNT_W] ? {CNT_W{1'b1}} : s[CNT_W-1:0];
  endfunction

  for (genvar k = 0; k < ISSUE_W; k++) begin : g_lane
    ucsbece154b_perf_lane #(.PC_LIMIT(PC_LIMIT)) u_lane (
      .valid    (valid_e_i[k]),
      .pc       (pc_e_i[32*k +: 32]),
      .op       (op_e_i[7*k +: 7]),
      .mispred  (mispred_i[k]),
      .taken    (taken_i[k]),
      .instr    (l_instr[k]),
      .br       (l_br[k]),
      .br_miss  (l_br_miss[k]),
      .jmp      (l_jmp[k]),
      .jmp_miss (l_jmp_miss[k])
    );
  end

  // Per-cycle increments: CYC, INSTR, BR, BR_MISS, JMP, JMP_MISS
  always_comb begin
    for (int i = 0; i < NCNT; i++) inc[i] = 3'd0;
    inc[0] = 3'd1;
    for (int k = 0; k < ISSUE_W; k++) begin
      inc[1] = inc[1] + {2'b0, l_instr[k]};
      inc[2] = inc[2] + {2'b0, l_br[k]};
      inc[3] = inc[3] + {2'b0, l_br_miss[k]};
      inc[4] = inc[4] + {2'b0, l_jmp[k]};
      inc[5] = inc[5] + {2'b0, l_jmp_miss[k]};
    end
  end

  assign cnt_en = (state == RUN) && !clear_i;
  // prev_vld keeps the first RUN cycle from comparing against a stale fetch PC
  assign halt = prev_vld && (pcf_i == prev_pcf) && (pc_e_i[31:0] == HALT_PC);
  assign tmo  = (MAX_CYC != 0) && (64'(cnt[0]) == 64'(MAX_CYC) - 64'd1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      prev_pcf  <= 32'd0;
      prev_vld  <= 1'b0;
      timeout_o <= 1'b0;
    end else if (clear_i) begin
      state     <= IDLE;
      prev_vld  <= 1'b0;
      timeout_o <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start_i) begin
          state    <= RUN;
          prev_vld <= 1'b0;
        end
        RUN: begin
          prev_pcf <= pcf_i;
          prev_vld <= 1'b1;
          if (halt) begin
            state     <= DONE;
            timeout_o <= 1'b0;
          end else if (tmo) begin
            state     <= DONE;
            timeout_o <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NCNT; i++) cnt[i] <= '0;
    end else if (clear_i) begin
      for (int i = 0; i < NCNT; i++) cnt[i] <= '0;
    end else if (cnt_en) begin
      for (int i = 0; i < NCNT; i++) cnt[i] <= sat_add(cnt[i], inc[i]);
    end
  end

`ifdef PERF_HIST_EN
  logic [CNT_W-1:0] hist [ISSUE_W+1];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int n = 0; n <= ISSUE_W; n++) hist[n] <= '0;
    end else if (clear_i) begin
      for (int n = 0; n <= ISSUE_W; n++) hist[n] <= '0;
    end else if (cnt_en) begin
      for (int n = 0; n <= ISSUE_W; n++)
        if (inc[1] == 3'(n)) hist[n] <= sat_add(hist[n], 3'd1);
    end
  end
`endif

  assign running_o = (state == RUN);
  assign done_o    = (state == DONE);

  always_comb begin
    rd_data_o = '0;
    case (rd_sel_i)
      4'd0: rd_data_o = cnt[0];
      4'd1: rd_data_o = cnt[1];
      4'd2: rd_data_o = cnt[2];
      4'd3: rd_data_o = cnt[3];
      4'd4: rd_data_o = cnt[4];
      4'd5: rd_data_o = cnt[5];
      4'd6: rd_data_o = {{(CNT_W-3){1'b0}}, timeout_o, done_o, running_o};
      default: begin
`ifdef PERF_HIST_EN
        for (int n = 0; n <= ISSUE_W; n++)
          if (rd_sel_i == 4'(8 + n)) rd_data_o = hist[n];
`endif
      end
    endcase
  end
endmodule
